ram_stream_reader: RTL and testbench

Initiator-side block that reads a contiguous address window out of the single-port RAM and streams the words out on a valid/ready interface. It drives the RAM's wrEn/addr pins and consumes its dataOut. It is used to dump core-local data memory to the host/UART path after a run. It hides the RAM's 1-cycle read latency and absorbs consumer backpressure with a 2-entry output buffer.

---
 rtl/ram_stream_reader_if.sv | 37 +++
 rtl/ram_stream_reader.sv | 140 ++++++++++++++
 tb/tb_ram_stream_reader.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ram_stream_reader_if.sv
// ============================================================================
// Module   : ram_stream_reader_if
// Purpose  : Control, RAM-port and output-stream signals of ram_stream_reader.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ram_stream_reader_if #(
    parameter int WIDTH      = 12,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] startAddr;
    logic [ADDR_WIDTH:0]   count;
    logic                  busy;
    logic                  done;
    logic                  ramWrEn;
    logic [ADDR_WIDTH-1:0] ramAddr;
    logic [WIDTH-1:0]      ramDataOut;
    logic [WIDTH-1:0]      outData;
    logic                  outValid;
    logic                  outReady;
    logic                  outLast;

    modport master (
        input  start, startAddr, count, ramDataOut, outReady,
        output busy, done, ramWrEn, ramAddr, outData, outValid, outLast
    );

    modport slave (
        output start, startAddr, count, ramDataOut, outReady,
        input  busy, done, ramWrEn, ramAddr, outData, outValid, outLast
    );
endinterface

`default_nettype wire

// File: rtl/ram_stream_reader.sv
// ============================================================================
// Module   : ram_stream_reader
// Purpose  : Reads a contiguous RAM window and streams it out through a
//            2-entry buffer that hides the 1-cycle RAM read latency.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_stream_reader #(
    parameter int WIDTH      = 12,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    ram_stream_reader_if.master bus
);
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   r_issued;
    logic [ADDR_WIDTH:0]   r_accepted;
    logic                  r_inflight;
    logic [1:0]            r_occ;
    logic [WIDTH-1:0]      r_head;
    logic [WIDTH-1:0]      r_tail;

    logic                  w_valid;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_last;
    logic                  w_issue;
    logic                  w_more;
    logic [2:0]            w_slots;
    logic [ADDR_WIDTH-1:0] w_addr_next;

    always_comb begin
        w_valid     = (r_occ != 2'd0);
        w_pop       = w_valid & bus.outReady;
        w_push      = r_inflight;
        w_last      = ((r_accepted + 1'b1) == r_count);
        w_slots     = {1'b0, r_occ} + {2'b00, r_inflight};
        // A word leaving this cycle frees a slot for a read issued this cycle
        w_issue     = (r_state == S_RUN) && (r_issued < r_count) &&
                      (w_slots < (3'd2 + {2'b00, w_pop}));
        w_more      = ((r_issued + 1'b1) < r_count);
        w_addr_next = (r_addr == c_last_addr) ? '0 : r_addr + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_addr     <= '0;
            r_count    <= '0;
            r_issued   <= '0;
            r_accepted <= '0;
            r_inflight <= 1'b0;
            r_occ      <= 2'd0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_issue;

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_count    <= bus.count;
                        r_issued   <= '0;
                        r_accepted <= '0;
                        if (bus.count == '0) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                            r_addr  <= bus.startAddr;
                        end
                    end
                end
                S_RUN: begin
                    // ramAddr is pre-loaded with the next address; it stops on the final one
                    if (w_issue) begin
                        r_issued <= r_issued + 1'b1;
                        if (w_more) begin
                            r_addr <= w_addr_next;
                        end
                    end
                    if (w_pop) begin
                        r_accepted <= r_accepted + 1'b1;
                        if (w_last) begin
                            r_state <= S_FIN;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_push && ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_pop))) begin
                r_head <= bus.ramDataOut;
            end else if (w_pop && (r_occ == 2'd2)) begin
                r_head <= r_tail;
            end
            if (w_push && (((r_occ == 2'd1) && !w_pop) || ((r_occ == 2'd2) && w_pop))) begin
                r_tail <= bus.ramDataOut;
            end
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign bus.ramWrEn  = 1'b0;
    assign bus.ramAddr  = r_addr;
    assign bus.outData  = r_head;
    assign bus.outValid = w_valid;
    assign bus.outLast  = w_valid & w_last;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
// ============================================================================
// Module   : tb_ram_stream_reader
// Purpose  : Directed, table-driven checks of ram_stream_reader against a RAM model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ram_stream_reader;
    localparam int WIDTH = 12;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_stream_reader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus();

    ram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) bus.ramDataOut <= mem[bus.ramAddr];

    typedef struct packed {
        logic [2:0]        sa;
        logic [3:0]        cnt;
        logic              bp;
        logic              rs;
        logic [7:0][11:0]  exp;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int sa, input int cnt, input bit bp, input bit rs,
                                input int e0, input int e1, input int e2, input int e3,
                                input int e4, input int e5, input int e6, input int e7);
        vec_t v;
        v.sa = 3'(sa); v.cnt = 4'(cnt); v.bp = bp; v.rs = rs;
        v.exp[0] = 12'(e0); v.exp[1] = 12'(e1); v.exp[2] = 12'(e2); v.exp[3] = 12'(e3);
        v.exp[4] = 12'(e4); v.exp[5] = 12'(e5); v.exp[6] = 12'(e6); v.exp[7] = 12'(e7);
        return v;
    endfunction

    task automatic do_xfer(input vec_t v);
        int got = 0;
        int done_idx = -1;
        int last_idx = -1;
        int first_idx = -1;
        bit holding = 1'b0;
        logic [WIDTH-1:0] held = '0;
        int addrs[$];
        int n;
        bus.start = 1'b1; bus.startAddr = v.sa; bus.count = v.cnt;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (v.rs && cyc == 1) begin
                bus.start = 1'b1; bus.startAddr = 3'd6; bus.count = 4'd2;
            end else begin
                bus.start = 1'b0;
            end
            if (v.bp)
                bus.outReady = (cyc >= 4 && cyc < 9) ? 1'b0 : 1'($urandom_range(0, 1));
            else
                bus.outReady = 1'b1;
            if (addrs.size() == 0 || addrs[$] != int'(bus.ramAddr))
                addrs.push_back(int'(bus.ramAddr));
            if (holding && bus.outValid) chk("stall_stable", bus.outData, held);
            holding = bus.outValid && !bus.outReady;
            held    = bus.outData;
            if (bus.done) begin
                done_idx = cyc;
                break;
            end
            chk("busy_run", bus.busy, 1);
            if (bus.outValid && bus.outReady) begin
                if (got < 8) chk("data", bus.outData, v.exp[got]);
                chk("last", bus.outLast, (got == int'(v.cnt) - 1));
                if (got == 0) first_idx = cyc;
                got++;
                last_idx = cyc;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        chk("done_seen", (done_idx >= 0), 1);
        chk("done_timing", done_idx, last_idx + 1);
        chk("busy_at_done", bus.busy, 0);
        chk("valid_at_done", bus.outValid, 0);
        chk("word_count", got, v.cnt);
        if (!v.bp) chk("latency", first_idx, 2);
        chk("addr_count", addrs.size(), v.cnt);
        n = (addrs.size() < int'(v.cnt)) ? addrs.size() : int'(v.cnt);
        for (int i = 0; i < n; i++) chk("addr_seq", addrs[i], (int'(v.sa) + i) % DEPTH);
        chk("wr_en", bus.ramWrEn, 0);
        @(posedge clk); #1;
        chk("done_pulse", bus.done, 0);
    endtask

    initial begin
        int got;
        logic [2:0] addr_before;

        for (int i = 0; i < DEPTH; i++) mem[i] = 12'(100 + i);
        bus.start = 1'b0; bus.startAddr = '0; bus.count = '0; bus.outReady = 1'b0;

        vecs[0] = mk(2, 4, 0, 0, 102, 103, 104, 105, 0, 0, 0, 0);
        vecs[1] = mk(6, 4, 0, 0, 106, 107, 100, 101, 0, 0, 0, 0);
        vecs[2] = mk(0, 8, 1, 0, 100, 101, 102, 103, 104, 105, 106, 107);
        vecs[3] = mk(7, 1, 0, 0, 107, 0, 0, 0, 0, 0, 0, 0);
        vecs[4] = mk(3, 8, 0, 0, 103, 104, 105, 106, 107, 100, 101, 102);
        vecs[5] = mk(1, 3, 0, 1, 101, 102, 103, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_valid", bus.outValid, 0);
        chk("rst_last", bus.outLast, 0);
        chk("rst_addr", bus.ramAddr, 0);
        chk("rst_data", bus.outData, 0);
        chk("rst_wren", bus.ramWrEn, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 6; v++) do_xfer(vecs[v]);

        // Reset after two accepted words of a full-window transfer
        bus.start = 1'b1; bus.startAddr = 3'd0; bus.count = 4'd8; bus.outReady = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        got = 0;
        for (int cyc = 0; cyc < 50 && got < 2; cyc++) begin
            if (bus.outValid && bus.outReady) got++;
            if (got < 2) begin
                @(posedge clk); #1;
            end
        end
        chk("pre_rst_words", got, 2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_valid", bus.outValid, 0);
        chk("mid_rst_last", bus.outLast, 0);
        chk("mid_rst_addr", bus.ramAddr, 0);
        chk("mid_rst_data", bus.outData, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("post_rst_no_valid", bus.outValid, 0);
        end
        do_xfer(mk(5, 2, 0, 0, 105, 106, 0, 0, 0, 0, 0, 0));

        // Zero-length request
        addr_before = bus.ramAddr;
        bus.start = 1'b1; bus.startAddr = 3'd4; bus.count = 4'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("zero_done", bus.done, 1);
        chk("zero_busy", bus.busy, 0);
        chk("zero_valid", bus.outValid, 0);
        chk("zero_addr", bus.ramAddr, addr_before);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("zero_done_off", bus.done, 0);
            chk("zero_busy_off", bus.busy, 0);
            chk("zero_valid_off", bus.outValid, 0);
            chk("zero_addr_hold", bus.ramAddr, addr_before);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
